// File: rtl/sysid_checker.sv
// Reads the sysid slave (ID at address 0, timestamp at address 1) and compares both words with expected values.
// Optional stall watchdog: define SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd1114575596,
    parameter logic [31:0] EXPECTED_TS    = 32'd1224570194,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_word,
    output logic [31:0] ts_word
);

    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FINISH} state_t;

    state_t      state_q, state_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_word_q, id_word_d;
    logic [31:0] ts_word_q, ts_word_d;
    logic        expired;

`ifdef SYSID_CHECKER_TIMEOUT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb expired = (stall_cnt_q == 16'(TIMEOUT_CYCLES));

    // Counts consecutive stalled read cycles; restarts whenever the state changes.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_d != state_q)
            stall_cnt_d = '0;
        else if (read && waitrequest)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end
`else
    always_comb expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        timeout_d = timeout_q;
        id_word_d = id_word_q;
        ts_word_d = ts_word_q;
        read      = 1'b0;
        address   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = RD_ID;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RD_ID: begin
                if (expired) begin
                    state_d   = FINISH;
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                end else begin
                    read = 1'b1;
                    if (!waitrequest) begin
                        id_word_d = readdata;
                        state_d   = RD_TS;
                    end
                end
            end
            RD_TS: begin
                address = 1'b1;
                if (expired) begin
                    state_d   = FINISH;
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                end else begin
                    read = 1'b1;
                    // Compare results are registered here so they appear with done in FINISH.
                    if (!waitrequest) begin
                        ts_word_d = readdata;
                        id_ok_d   = (id_word_q == EXPECTED_ID);
                        ts_ok_d   = (readdata == EXPECTED_TS);
                        state_d   = FINISH;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            id_word_q <= '0;
            ts_word_q <= '0;
        end else begin
            state_q   <= state_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            timeout_q <= timeout_d;
            id_word_q <= id_word_d;
            ts_word_q <= ts_word_d;
        end
    end

    assign id_ok   = id_ok_q;
    assign ts_ok   = ts_ok_q;
    assign timeout = timeout_q;
    assign id_word = id_word_q;
    assign ts_word = ts_word_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed, table-driven bench for sysid_checker with a combinational sysid slave model.
module tb_sysid_checker;

`ifdef SYSID_CHECKER_TIMEOUT_EN
    localparam int unsigned TO    = 4;
    localparam int          STALL = 3;
`else
    localparam int unsigned TO    = 255;
    localparam int          STALL = 5;
`endif
    localparam logic [31:0] ID_GOOD = 32'd1114575596;
    localparam logic [31:0] TS_GOOD = 32'd1224570194;

    logic        clk = 1'b0;
    logic        reset, start, address, read, waitrequest;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] readdata, id_word, ts_word, id_val, ts_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb readdata = address ? ts_val : id_val;

    sysid_checker #(
        .EXPECTED_ID   (ID_GOOD),
        .EXPECTED_TS   (TS_GOOD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .address    (address),
        .read       (read),
        .readdata   (readdata),
        .waitrequest(waitrequest),
        .busy       (busy),
        .done       (done),
        .id_ok      (id_ok),
        .ts_ok      (ts_ok),
        .timeout    (timeout),
        .id_word    (id_word),
        .ts_word    (ts_word)
    );

    typedef struct {
        logic [31:0] id_v;
        logic [31:0] ts_v;
        logic        exp_id_ok;
        logic        exp_ts_ok;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses start and counts edges (start edge = 1) until done is seen.
    task automatic run_check(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        check("start_clears", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        check("rd_id_bus", {29'd0, busy, read, address}, 32'b110);
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    vec_t vecs[5];
    int   lat;
    int   dn;
    int   at[3];
    logic saw_done;

    initial begin
        vecs[0] = '{ID_GOOD,      TS_GOOD,               1'b1, 1'b1};
        vecs[1] = '{ID_GOOD,      32'h0000_0000,         1'b1, 1'b0};
        vecs[2] = '{32'hDEADBEEF, TS_GOOD,               1'b0, 1'b1};
        vecs[3] = '{ID_GOOD ^ 1,  TS_GOOD ^ 32'h80000000, 1'b0, 1'b0};
        vecs[4] = '{ID_GOOD,      TS_GOOD,               1'b1, 1'b1};

        reset = 1'b1; start = 1'b0; waitrequest = 1'b0; id_val = '0; ts_val = '0;
        #12;
        check("reset_ctrl", {25'd0, busy, read, address, done, id_ok, ts_ok, timeout}, 32'd0);
        check("reset_id_word", id_word, 32'd0);
        check("reset_ts_word", ts_word, 32'd0);
        reset = 1'b0;

        // First vector starts straight out of reset; latency 3 proves the first edge accepts it.
        for (int unsigned i = 0; i < 5; i++) begin
            id_val = vecs[i].id_v;
            ts_val = vecs[i].ts_v;
            run_check(lat);
            check("latency", 32'(lat), 32'd3);
            check("id_ok", {31'd0, id_ok}, {31'd0, vecs[i].exp_id_ok});
            check("ts_ok", {31'd0, ts_ok}, {31'd0, vecs[i].exp_ts_ok});
            check("id_word", id_word, vecs[i].id_v);
            check("ts_word", ts_word, vecs[i].ts_v);
            check("timeout_clear", {31'd0, timeout}, 32'd0);
            tick();
            check("done_one_cycle", {30'd0, done, busy}, 32'd0);
            check("id_ok_held", {31'd0, id_ok}, {31'd0, vecs[i].exp_id_ok});
            check("ts_word_held", ts_word, vecs[i].ts_v);
        end

        // Stall on the ID read.
        id_val = ID_GOOD; ts_val = TS_GOOD;
        waitrequest = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        for (int s = 0; s < STALL; s++) begin
            check("stall_hold", {30'd0, read, address}, 32'b10);
            tick();
            lat++;
        end
        waitrequest = 1'b0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check("stall_latency", 32'(lat), 32'(3 + STALL));
        check("stall_ok", {30'd0, id_ok, ts_ok}, 32'b11);
        tick();

        // Start held for 10 edges: only three checks may run.
        dn = 0;
        at[0] = 0; at[1] = 0; at[2] = 0;
        start = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 10) start = 1'b0;
            if (done) begin
                if (dn < 3) at[dn] = e;
                dn++;
            end
        end
        check("burst_count", 32'(dn), 32'd3);
        check("burst_done0", 32'(at[0]), 32'd3);
        check("burst_done1", 32'(at[1]), 32'd7);
        check("burst_done2", 32'(at[2]), 32'd11);

`ifdef SYSID_CHECKER_TIMEOUT_EN
        waitrequest = 1'b1;
        run_check(lat);
        check("to_latency", 32'(lat), 32'(TO + 2));
        check("to_flags", {29'd0, timeout, id_ok, ts_ok}, 32'b100);
        tick();
        check("to_done_one_cycle", {30'd0, done, busy}, 32'd0);
        check("to_held", {31'd0, timeout}, 32'd1);
        waitrequest = 1'b0;
`endif

        // Reset in the middle of RD_TS.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("in_rd_ts", {30'd0, read, address}, 32'b11);
        #2 reset = 1'b1;
        #1;
        check("midreset_ctrl", {25'd0, busy, read, address, done, id_ok, ts_ok, timeout}, 32'd0);
        check("midreset_id_word", id_word, 32'd0);
        check("midreset_ts_word", ts_word, 32'd0);
        tick();
        #2 reset = 1'b0;
        saw_done = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("no_done_after_reset", {31'd0, saw_done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
